// File: rtl/cluster_reduce_pipe.sv
// N-channel XOR/ADD/AND/OR reduction feeding a DEPTH-stage valid/ready pipeline with an output accumulator.
// Optional macro CLUSTER_REDUCE_PARITY_EN adds out_parity, carried alongside out_data.
module cluster_reduce_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
`ifdef CLUSTER_REDUCE_PARITY_EN
    output logic                    out_parity,
`endif
    input  logic                    acc_clear,
    output logic [WIDTH-1:0]        out_acc,
    output logic [15:0]             out_count
);

    localparam logic [1:0] MODE_XOR = 2'd0;
    localparam logic [1:0] MODE_ADD = 2'd1;
    localparam logic [1:0] MODE_AND = 2'd2;
    localparam logic [1:0] MODE_OR  = 2'd3;

    logic [WIDTH-1:0] reduce_s;
    logic [DEPTH-1:0] stage_ready_s;
    logic             chain_s;
    logic [DEPTH-1:0] prev_valid_s;
    logic [WIDTH-1:0] prev_data_s [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic             out_hs_s;
    logic [WIDTH-1:0] acc_r;
    logic [15:0]      count_r;

    // Fold all channels with the selected operator; ADD wraps at WIDTH bits.
    always_comb begin
        reduce_s = in_data[WIDTH-1:0];
        for (int i = 1; i < NUM_IN; i++) begin
            case (in_mode)
                MODE_XOR: reduce_s = reduce_s ^ in_data[i*WIDTH +: WIDTH];
                MODE_ADD: reduce_s = reduce_s + in_data[i*WIDTH +: WIDTH];
                MODE_AND: reduce_s = reduce_s & in_data[i*WIDTH +: WIDTH];
                MODE_OR:  reduce_s = reduce_s | in_data[i*WIDTH +: WIDTH];
                default:  reduce_s = reduce_s;
            endcase
        end
    end

    // A stage can load when it is empty or everything downstream of it can advance.
    always_comb begin
        stage_ready_s = {DEPTH{1'b0}};
        chain_s       = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain_s          = !valid_r[k] || chain_s;
            stage_ready_s[k] = chain_s;
        end
    end

    assign in_ready = stage_ready_s[0] && !rst;

    // Predecessor view of every stage; stage 0's predecessor is the input port.
    always_comb begin
        prev_valid_s[0] = in_valid;
        prev_data_s[0]  = reduce_s;
        for (int k = 1; k < DEPTH; k++) begin
            prev_valid_s[k] = valid_r[k-1];
            prev_data_s[k]  = data_r[k-1];
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (stage_ready_s[k]) begin
                    valid_r[k] <= prev_valid_s[k];
                    data_r[k]  <= prev_data_s[k];
                end
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign out_hs_s  = out_valid && out_ready;

    // Running sum and saturating count of delivered results; a clear seeds them with the current delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= 16'd0;
        end else if (out_hs_s) begin
            if (acc_clear) begin
                acc_r   <= out_data;
                count_r <= 16'd1;
            end else begin
                acc_r   <= acc_r + out_data;
                count_r <= (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
            end
        end else if (acc_clear) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= 16'd0;
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    assign out_acc   = acc_r;
    assign out_count = count_r;

`ifdef CLUSTER_REDUCE_PARITY_EN
    logic [DEPTH-1:0] parity_r;
    logic [DEPTH-1:0] prev_parity_s;

    function automatic logic parity_of(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    // Parity rides next to the data so it stays aligned and held under stall.
    always_comb begin
        prev_parity_s[0] = parity_of(reduce_s);
        for (int k = 1; k < DEPTH; k++) begin
            prev_parity_s[k] = parity_r[k-1];
        end
    end

    // Parity stage registers, advancing with the data stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= {DEPTH{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (stage_ready_s[k]) begin
                    parity_r[k] <= prev_parity_s[k];
                end
            end
        end
    end

    assign out_parity = parity_r[DEPTH-1];
`endif

endmodule
